// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter sequencer.
//   WORD_BYTES / WORD_SHIFT : instruction word size in bytes and as a shift.
//   REGION_SHIFT            : bit position of the region field kept by an
//                             absolute jump.
//   DEFAULT_*_VECTOR        : default reset and exception fetch addresses.
//   pc_sel_e                : the request that wins the next-PC choice.
package pc_pkg;

    localparam int          WORD_BYTES           = 4;
    localparam int          WORD_SHIFT           = 2;
    localparam int          REGION_SHIFT         = 28;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_EXC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack held in a circular buffer.
//   clk, rst     : clock, synchronous active-high reset (control state only).
//   push_i       : write data_i as the new top entry.
//   pop_i        : discard the top entry (ignored when empty).
//   data_i       : return address to push.
//   top_o        : current top entry (combinational read).
//   count_o      : number of valid entries, 0..DEPTH.
//   overflow_o   : registered pulse, a push found the stack full.
//   underflow_o  : registered pulse, a pop found the stack empty.
// push_i and pop_i are never asserted together by the sequencer.
module ras_stack #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] top_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  sp_q;      // next slot to write
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic              unf_q;
    logic              full;
    logic              empty;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign top_idx = sp_q - PTR_W'(1);
    assign top_o   = mem_q[top_idx];

    // When full, sp_q already points at the oldest entry, so a push simply
    // overwrites it and the count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ovf_q <= push_i && full;
            unf_q <= pop_i && empty;
            if (push_i) begin
                sp_q <= sp_q + PTR_W'(1);
                if (!full) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (pop_i && !empty) begin
                sp_q    <= top_idx;
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[sp_q] <= data_i;
        end
    end

    assign count_o     = count_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer with branch, region jump, call/return
// through a return-address stack, exception redirect and stall.
//   clk, rst       : clock, synchronous active-high reset.
//   stall          : hold PC, EPC and RAS this cycle (exception still wins).
//   branch_taken   : PC-relative branch by branch_offset words.
//   branch_offset  : signed word offset.
//   jump, link     : absolute jump inside the current 256 MB region; link
//                    also pushes the return address.
//   jump_target    : word index within the region.
//   ret            : return to the RAS top entry.
//   exception      : redirect to EXC_VECTOR and capture the PC in epc_out.
//   pc_out         : registered fetch PC.
//   pc_plus4       : combinational pc_out + 4.
//   epc_out        : PC captured at the last exception.
//   ras_count      : valid RAS entries.
//   ras_overflow   : one-cycle pulse, push into a full RAS.
//   ras_underflow  : one-cycle pulse, ret with an empty RAS.
module pc_sequencer import pc_pkg::*; #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR),
    parameter int                RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic [ADDR_W-1:0]              branch_offset,
    input  logic                           jump,
    input  logic                           link,
    input  logic [25:0]                    jump_target,
    input  logic                           ret,
    input  logic                           exception,
    output logic [ADDR_W-1:0]              pc_out,
    output logic [ADDR_W-1:0]              pc_plus4,
    output logic [ADDR_W-1:0]              epc_out,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic [ADDR_W-1:0]        epc_q, epc_d;
    logic signed [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0]        br_target;
    logic [ADDR_W-1:0]        jmp_target;
    logic [ADDR_W-1:0]        ras_top;
    logic                     ras_push;
    logic                     ras_pop;
    pc_sel_e                  sel;

    assign pc_plus4   = pc_q + ADDR_W'(WORD_BYTES);
    assign br_off_s   = $signed(branch_offset);
    // Wraps silently modulo 2^ADDR_W.
    assign br_target  = pc_plus4 + $unsigned(br_off_s <<< WORD_SHIFT);
    assign jmp_target = {pc_plus4[ADDR_W-1:REGION_SHIFT], jump_target, 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        if (exception) begin
            sel = SEL_EXC;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (branch_taken) begin
            sel = SEL_BRANCH;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (ret) begin
            sel = SEL_RET;
        end
    end

    // Only the winning request may touch the RAS.
    assign ras_push = (sel == SEL_JUMP) && link;
    assign ras_pop  = (sel == SEL_RET);

    always_comb begin
        pc_d  = pc_plus4;
        epc_d = epc_q;
        case (sel)
            SEL_EXC: begin
                pc_d  = EXC_VECTOR;
                epc_d = pc_q;
            end
            SEL_HOLD:   pc_d = pc_q;
            SEL_BRANCH: pc_d = br_target;
            SEL_JUMP:   pc_d = jmp_target;
            SEL_RET:    pc_d = (ras_count != '0) ? ras_top : pc_plus4;
            default:    pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
        end
    end

    ras_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .data_i      (pc_plus4),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    assign pc_out  = pc_q;
    assign epc_out = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic        link;
    logic [25:0] jump_target;
    logic        ret;
    logic        exception;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] epc_out;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks   = 0;
    int failures = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .link          (link),
        .jump_target   (jump_target),
        .ret           (ret),
        .exception     (exception),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .epc_out       (epc_out),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; link = 1'b0; jump_target = '0; ret = 1'b0; exception = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; exception = 1'b1; jump = 1'b1; link = 1'b1; ret = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h3000) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", pc_out, 32'h3000); end
        checks++; if (epc_out !== 32'h0) begin failures++; $display("FAIL reset_epc actual=%h expected=%h", epc_out, 32'h0); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", ras_count); end
        checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin failures++; $display("FAIL reset_pulses actual=%b%b expected=00", ras_overflow, ras_underflow); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_seq [3] = '{32'h3004, 32'h3008, 32'h300C};
        do_reset();
        checks++; if (pc_plus4 !== 32'h3004) begin failures++; $display("FAIL seq_plus4 actual=%h expected=%h", pc_plus4, 32'h3004); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_out !== exp_seq[i]) begin failures++; $display("FAIL seq_pc%0d actual=%h expected=%h", i, pc_out, exp_seq[i]); end
        end
    endtask

    task automatic test_branch();
        tick();  // 0x3010
        checks++; if (pc_out !== 32'h3010) begin failures++; $display("FAIL br_start actual=%h expected=%h", pc_out, 32'h3010); end
        branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFE;
        tick();
        checks++; if (pc_out !== 32'h300C) begin failures++; $display("FAIL br_back actual=%h expected=%h", pc_out, 32'h300C); end
        // 0x3010 + 0xFFFFCFE8 = 0xFFFFFFF8
        branch_offset = 32'h3FFF_F3FA;
        tick();
        checks++; if (pc_out !== 32'hFFFF_FFF8) begin failures++; $display("FAIL br_far actual=%h expected=%h", pc_out, 32'hFFFF_FFF8); end
        // 0xFFFFFFFC + 0xFFFFFFFC wraps to 0xFFFFFFF8
        branch_offset = 32'h3FFF_FFFF;
        tick();
        checks++; if (pc_out !== 32'hFFFF_FFF8) begin failures++; $display("FAIL br_wrap actual=%h expected=%h", pc_out, 32'hFFFF_FFF8); end
        idle_inputs();
        // Jump keeps region bits of pc_plus4 (0xF...)
        jump = 1'b1; jump_target = 26'h10;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'hF000_0040) begin failures++; $display("FAIL jump_region actual=%h expected=%h", pc_out, 32'hF000_0040); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL jump_nolink_count actual=%0d expected=0", ras_count); end
    endtask

    task automatic test_call_ret();
        do_reset();
        jump = 1'b1; link = 1'b1; jump_target = 26'h400;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h1000) begin failures++; $display("FAIL call_pc actual=%h expected=%h", pc_out, 32'h1000); end
        checks++; if (ras_count !== 3'd1) begin failures++; $display("FAIL call_count actual=%0d expected=1", ras_count); end
        tick();
        checks++; if (pc_out !== 32'h1004) begin failures++; $display("FAIL call_body actual=%h expected=%h", pc_out, 32'h1004); end
        ret = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h3004) begin failures++; $display("FAIL ret_pc actual=%h expected=%h", pc_out, 32'h3004); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL ret_count actual=%0d expected=0", ras_count); end
        checks++; if (ras_underflow !== 1'b0) begin failures++; $display("FAIL ret_unf actual=%b expected=0", ras_underflow); end
    endtask

    task automatic test_priority();
        do_reset();
        jump = 1'b1; link = 1'b1; jump_target = 26'h100;
        tick();  // pc 0x400, push 0x3004
        // branch beats jump+link and ret: no RAS change
        branch_taken = 1'b1; branch_offset = 32'd4; ret = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h414) begin failures++; $display("FAIL prio_branch_pc actual=%h expected=%h", pc_out, 32'h414); end
        checks++; if (ras_count !== 3'd1) begin failures++; $display("FAIL prio_branch_count actual=%0d expected=1", ras_count); end
        // jump without link beats ret
        jump = 1'b1; jump_target = 26'h200; ret = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h800) begin failures++; $display("FAIL prio_jump_pc actual=%h expected=%h", pc_out, 32'h800); end
        checks++; if (ras_count !== 3'd1) begin failures++; $display("FAIL prio_jump_count actual=%0d expected=1", ras_count); end
        // link alone is ignored
        link = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h804 || ras_count !== 3'd1) begin failures++; $display("FAIL link_only actual=%h/%0d expected=00000804/1", pc_out, ras_count); end
        ret = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h3004) begin failures++; $display("FAIL prio_ret_pc actual=%h expected=%h", pc_out, 32'h3004); end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] call_pc [5] = '{32'h400, 32'h800, 32'hC00, 32'h1000, 32'h1400};
        logic [2:0]  call_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [31:0] ret_pc [5] = '{32'h1004, 32'hC04, 32'h804, 32'h404, 32'h408};
        logic [2:0]  ret_cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            jump = 1'b1; link = 1'b1; jump_target = 26'(32'h100 * (i + 1));
            tick();
            checks++; if (pc_out !== call_pc[i] || ras_count !== call_cnt[i] || ras_overflow !== (i == 4)) begin
                failures++; $display("FAIL nest_call%0d actual=%h/%0d/%b expected=%h/%0d/%b", i, pc_out, ras_count, ras_overflow, call_pc[i], call_cnt[i], (i == 4));
            end
        end
        idle_inputs();
        tick();
        checks++; if (ras_overflow !== 1'b0 || pc_out !== 32'h1404) begin failures++; $display("FAIL ovf_pulse_end actual=%b/%h expected=0/00001404", ras_overflow, pc_out); end
        for (int i = 0; i < 5; i++) begin
            ret = 1'b1;
            tick();
            checks++; if (pc_out !== ret_pc[i] || ras_count !== ret_cnt[i] || ras_underflow !== (i == 4)) begin
                failures++; $display("FAIL nest_ret%0d actual=%h/%0d/%b expected=%h/%0d/%b", i, pc_out, ras_count, ras_underflow, ret_pc[i], ret_cnt[i], (i == 4));
            end
        end
        idle_inputs();
        tick();
        checks++; if (ras_underflow !== 1'b0 || pc_out !== 32'h40C) begin failures++; $display("FAIL unf_pulse_end actual=%b/%h expected=0/0000040c", ras_underflow, pc_out); end
    endtask

    task automatic test_exception_stall();
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        checks++; if (pc_out !== 32'h3020) begin failures++; $display("FAIL exc_start actual=%h expected=%h", pc_out, 32'h3020); end
        exception = 1'b1; stall = 1'b1; jump = 1'b1; link = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h80) begin failures++; $display("FAIL exc_pc actual=%h expected=%h", pc_out, 32'h80); end
        checks++; if (epc_out !== 32'h3020) begin failures++; $display("FAIL exc_epc actual=%h expected=%h", epc_out, 32'h3020); end
        checks++; if (ras_count !== 3'd0) begin failures++; $display("FAIL exc_count actual=%0d expected=0", ras_count); end
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; ret = 1'b1; jump = (i == 1); link = (i == 1);
            tick();
            checks++; if (pc_out !== 32'h80 || ras_count !== 3'd0 || ras_underflow !== 1'b0) begin
                failures++; $display("FAIL stall_hold%0d actual=%h/%0d/%b expected=00000080/0/0", i, pc_out, ras_count, ras_underflow);
            end
        end
        idle_inputs();
        tick();
        checks++; if (pc_out !== 32'h84 || epc_out !== 32'h3020) begin failures++; $display("FAIL stall_release actual=%h/%h expected=00000084/00003020", pc_out, epc_out); end
    endtask

    task automatic test_reset_mid_call();
        jump = 1'b1; link = 1'b1; jump_target = 26'h400;
        tick();
        idle_inputs();
        checks++; if (ras_count !== 3'd1) begin failures++; $display("FAIL midcall_count actual=%0d expected=1", ras_count); end
        rst = 1'b1; ret = 1'b1; exception = 1'b1;
        tick();
        idle_inputs();
        checks++; if (pc_out !== 32'h3000 || ras_count !== 3'd0) begin failures++; $display("FAIL midcall_reset actual=%h/%0d expected=00003000/0", pc_out, ras_count); end
        checks++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0 || epc_out !== 32'h0) begin
            failures++; $display("FAIL midcall_flags actual=%b%b/%h expected=00/00000000", ras_overflow, ras_underflow, epc_out);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_priority();
        test_overflow_underflow();
        test_exception_stall();
        test_reset_mid_call();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
